// File: rtl/fp32_pkg.sv
// fp32_pkg: fp32 field constants, FSM state type and field unpack helper shared by the multiplier
package fp32_pkg;
  localparam int FP_BIAS = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fsm_e;
  typedef struct {
    logic s;
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] m;
  } fp32_t;
  function automatic fp32_t unpack_fp(input logic [31:0] x);
    unpack_fp.s = x[31];
    unpack_fp.e = x[30:23];
    unpack_fp.m = x[22:0];
  endfunction
endpackage

// File: rtl/mant_mul_iter.sv
// mant_mul_iter: 24x24 shift-add mantissa multiplier retiring MBPC multiplier bits per cycle
//   clk, rst  clock, sync active-high reset
//   start     load a_i/b_i and clear the accumulator
//   a_i, b_i  24-bit mantissas with hidden bit
//   done      high during the final accumulation cycle
//   prod      48-bit product, final on the cycle after done
module mant_mul_iter #(
  parameter int MBPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  output logic        done,
  output logic [47:0] prod
);
  localparam int STEPS = 24 / MBPC;
  logic [23:0] mcand_q, mplr_q;
  logic [47:0] acc_q, sum;
  logic [5:0] sh_q;
  logic [4:0] cnt_q;
  logic busy_q;
  always_comb begin
    sum = acc_q;
    for (int i = 0; i < MBPC; i++)
      if (mplr_q[i]) sum = sum + ({24'd0, mcand_q} << (sh_q + 6'(i)));
  end
  assign done = busy_q && cnt_q == 5'(STEPS - 1);
  assign prod = acc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      acc_q   <= '0;
      mcand_q <= a_i;
      mplr_q  <= b_i;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else if (busy_q) begin
      acc_q  <= sum;
      mplr_q <= mplr_q >> MBPC;
      sh_q   <= sh_q + 6'(MBPC);
      cnt_q  <= cnt_q + 5'd1;
      busy_q <= !done;
    end
  end
endmodule

// File: rtl/floating_mul_seq.sv
// floating_mul_seq: multi-cycle fp32 multiplier with valid/ready handshakes and overflow/underflow/invalid flags
//   in_valid/in_ready, operand_A/operand_B  operand handshake (ready only in IDLE)
//   out_valid/out_ready, mul_res            result handshake, held in DONE until out_ready
//   overflow, underflow, invalid            result flags, valid with out_valid
//   ROUND_NEAREST_EN defined: round-to-nearest-even, otherwise truncate
import fp32_pkg::*;
module floating_mul_seq #(
  parameter int MBPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mul_res,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);
  fsm_e state_q;
  fp32_t fa, fb;
  logic sign_q, ovf_q, unf_q, inv_q;
  logic [31:0] res_q;
  logic signed [9:0] exp_q, e_fin;
  logic za, zb, ia, ib, accept, special, s_inv, s_zero, sign, mul_done, norm;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_r;
  assign fa = unpack_fp(operand_A);
  assign fb = unpack_fp(operand_B);
  assign za = fa.e == '0;
  assign zb = fb.e == '0;
  assign ia = &fa.e;
  assign ib = &fb.e;
  assign s_inv = (za & ib) | (ia & zb);
  assign s_zero = za | zb;
  assign special = s_zero | ia | ib;
  assign sign = fa.s ^ fb.s;
  assign accept = in_valid && state_q == IDLE;
  mant_mul_iter #(.MBPC(MBPC)) u_mul (
    .clk(clk), .rst(rst), .start(accept && !special),
    .a_i({1'b1, fa.m}), .b_i({1'b1, fb.m}), .done(mul_done), .prod(prod)
  );
  assign norm = prod[47];
  assign mant = norm ? prod[46:24] : prod[45:23];
`ifdef ROUND_NEAREST_EN
  logic guard, sticky;
  assign guard = norm ? prod[23] : prod[22];
  assign sticky = norm ? |prod[22:0] : |prod[21:0];
  assign mant_r = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
`else
  logic unused_low;
  assign unused_low = ^prod[21:0];
  assign mant_r = {1'b0, mant};
`endif
  // an all-ones mantissa that rounds up wraps to zero and bumps the exponent
  assign e_fin = exp_q + 10'(norm) + 10'(mant_r[23]);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign mul_res = res_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  assign invalid = inv_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          sign_q <= sign;
          exp_q  <= $signed({2'b00, fa.e}) + $signed({2'b00, fb.e}) - 10'(FP_BIAS);
          state_q <= special ? DONE : MUL;
          if (special) begin
            res_q <= s_inv ? FP_QNAN : s_zero ? {sign, 31'd0} : {sign, 8'hFF, 23'd0};
            inv_q <= s_inv;
            ovf_q <= !s_zero;
          end
        end
        MUL: if (mul_done) state_q <= NORM;
        NORM: begin
          state_q <= DONE;
          ovf_q <= e_fin >= 10'sd255;
          unf_q <= e_fin <= 10'sd0;
          res_q <= e_fin >= 10'sd255 ? {sign_q, 8'hFF, 23'd0} :
                   e_fin <= 10'sd0 ? {sign_q, 31'd0} : {sign_q, e_fin[7:0], mant_r[22:0]};
        end
        DONE: if (out_ready) begin
          state_q <= IDLE;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
          inv_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_mul_seq.sv
// tb_floating_mul_seq: scoreboard bench for floating_mul_seq (MBPC=1)
module tb_floating_mul_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0, mul_res;
  logic in_ready, out_valid, overflow, underflow, invalid;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
  } exp_t;
  exp_t sb[$];
  floating_mul_seq #(.MBPC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_A(a), .operand_B(b), .out_valid(out_valid), .out_ready(out_ready),
    .mul_res(mul_res), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [31:0] opa, input logic [31:0] opb, input logic [31:0] res,
                        input logic [2:0] fl, input int lat, input int hold);
    exp_t e;
    int cyc;
    logic [31:0] held;
    sb.push_back('{res, fl, lat});
    check("rdy_before", 32'(in_ready), 32'd1);
    a = opa;
    b = opb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("rdy_drop", 32'(in_ready), 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    e = sb.pop_front();
    check("valid", 32'(out_valid), 32'd1);
    check("res", mul_res, e.res);
    check("flags", 32'({overflow, underflow, invalid}), 32'(e.fl));
    check("latency", 32'(cyc), 32'(e.lat));
    held = mul_res;
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_res", mul_res, held);
      check("hold_rdy", 32'(in_ready), 32'd0);
      check("hold_vld", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("idle_vld", 32'(out_valid), 32'd0);
    check("idle_rdy", 32'(in_ready), 32'd1);
    check("idle_flags", 32'({overflow, underflow, invalid}), 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int bad;
    logic [31:0] rnd_exp;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_res", mul_res, 32'd0);
    check("rst_flags", 32'({overflow, underflow, invalid}), 32'd0);
    rst = 1'b0;
    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 0);
    run_op(32'hBF000000, 32'h40800000, 32'hC0000000, 3'b000, 26, 0);
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);
    run_op(32'h00000000, 32'h40A00000, 32'h00000000, 3'b000, 1, 0);
    run_op(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1, 0);
    run_op(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b001, 1, 0);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b100, 1, 0);
    run_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b100, 26, 0);
    run_op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 26, 0);
`ifdef ROUND_NEAREST_EN
    rnd_exp = 32'h3FC00002;
`else
    rnd_exp = 32'h3FC00001;
`endif
    run_op(32'h3F800001, 32'h3FC00000, rnd_exp, 3'b000, 26, 0);
    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 5);
    run_op(32'hBF000000, 32'h40800000, 32'hC0000000, 3'b000, 26, 0);
    a = 32'h40000000;
    b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rdy", 32'(in_ready), 32'd1);
    check("abort_vld", 32'(out_valid), 32'd0);
    check("abort_res", mul_res, 32'd0);
    check("abort_flags", 32'({overflow, underflow, invalid}), 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) bad++;
    end
    check("abort_no_pulse", 32'(bad), 32'd0);
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
